pc_next_unit: RTL

Parametrised program-counter stage for the datapath: holds the PC register and selects the next PC from sequential increment, PC-relative branch, absolute jump or subroutine return. It is the next generation of the 2:1 PC select: the select is widened to four sources, the width and increment are parameters, and the PC is registered with a stall. A compile-time return-address stack (RAS) can be included. It sits between the control unit (select/call/enable) and the instruction-memory address port.

---
 rtl/pc_next_unit.sv | 68 ++++++
 1 files changed

// File: rtl/pc_next_unit.sv
// pc_next_unit: registered PC with 4-way next-PC select; return-address stack included when PC_NEXT_RAS_EN is defined.
module pc_next_unit #(
    parameter int WIDTH = 16,
    parameter int INC = 1,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] offset,
    input  logic [WIDTH-1:0] target,
    input  logic             call,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);
    logic [WIDTH-1:0] seq;
    logic [WIDTH-1:0] ret;
    assign seq = pc + WIDTH'(INC);
`ifdef PC_NEXT_RAS_EN
    localparam int AW = $clog2(RAS_DEPTH);
    logic [WIDTH-1:0] stack [RAS_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW:0] count;
    logic push, pop, has_top;
    assign push = en && sel == 2'b10 && call;
    assign pop = en && sel == 2'b11;
    assign has_top = count != '0;
    assign ras_empty = !has_top;
    assign ras_full = count == (AW+1)'(RAS_DEPTH);
    // an empty pop falls back to the sequential address
    assign ret = has_top ? stack[wr_ptr - 1'b1] : seq;
    always_ff @(posedge clk)
        if (push) stack[wr_ptr] <= seq;
    // wr_ptr wraps, so a push when full overwrites the oldest entry
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            count <= '0;
            ras_err <= 1'b0;
        end else if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            count <= ras_full ? count : count + 1'b1;
            ras_err <= ras_err | ras_full;
        end else if (pop) begin
            wr_ptr <= has_top ? wr_ptr - 1'b1 : wr_ptr;
            count <= has_top ? count - 1'b1 : count;
            ras_err <= ras_err | !has_top;
        end
`else
    logic unused_call;
    assign unused_call = call;
    assign ret = seq;
    assign ras_empty = 1'b1;
    assign ras_full = 1'b0;
    assign ras_err = 1'b0;
`endif
    assign pc_next = sel == 2'b00 ? seq :
                     sel == 2'b01 ? pc + offset :
                     sel == 2'b10 ? target : ret;
    always_ff @(posedge clk or posedge rst)
        if (rst) pc <= RESET_VEC;
        else if (en) pc <= pc_next;
endmodule
